// File: rtl/huc_mem_seq.sv
// huc_mem_seq: sequences HuCard mapper ROM/RAM requests onto one shared
// 8-bit asynchronous SRAM bus with setup / strobe / hold timing.
// ROM occupies the bottom of the device; cart RAM sits at RAM_BASE.
module huc_mem_seq #(
    parameter int unsigned T_ACC    = 4,
    parameter int unsigned T_WR     = 3,
    parameter logic [21:0] RAM_BASE = 22'h100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rom_ce,
    input  logic        rom_oe,
    input  logic [19:0] rom_addr,
    input  logic        ram_ce,
    input  logic        ram_oe,
    input  logic        ram_we,
    input  logic [17:0] ram_addr,
    input  logic [7:0]  ram_dati,
    output logic [7:0]  rom_dato,
    output logic [7:0]  ram_dato,
    output logic        busy,
    output logic [21:0] mem_addr,
    output logic [7:0]  mem_dq_o,
    output logic        mem_dq_oe,
    input  logic [7:0]  mem_dq_i,
    output logic        mem_ce_n,
    output logic        mem_oe_n,
    output logic        mem_we_n
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_STROBE = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    localparam logic [1:0] K_ROM_RD = 2'd0;
    localparam logic [1:0] K_RAM_RD = 2'd1;
    localparam logic [1:0] K_RAM_WR = 2'd2;

    // Strobe counters count down to zero, so load length minus one.
    localparam logic [3:0] ACC_LOAD = 4'(T_ACC - 1);
    localparam logic [3:0] WR_LOAD  = 4'(T_WR - 1);

    logic [1:0]  state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    logic [1:0]  kind_r, kind_s;
    logic        rom_prev_r, rd_prev_r, wr_prev_r;
    logic        pend_rom_r, pend_rd_r, pend_wr_r;
    logic        pend_rom_s, pend_rd_s, pend_wr_s;
    logic [19:0] rom_addr_r, rom_addr_s;
    logic [17:0] rd_addr_r, rd_addr_s;
    logic [17:0] wr_addr_r, wr_addr_s;
    logic [7:0]  wr_data_r, wr_data_s;

    logic        rom_req_s, rd_req_s, wr_req_s;
    logic        rom_edge_s, rd_edge_s, wr_edge_s;
    logic        want_rom_s, want_rd_s, want_wr_s, want_any_s;
    logic [1:0]  launch_kind_s;
    logic [21:0] launch_addr_s;

    logic [7:0]  rom_dato_s, ram_dato_s;
    logic        busy_s;
    logic [21:0] mem_addr_s;
    logic [7:0]  mem_dq_o_s;
    logic        mem_dq_oe_s, mem_ce_n_s, mem_oe_n_s, mem_we_n_s;

    // Request detection, merging, arbitration and next-state/output decode.
    always_comb begin
        rom_req_s  = rom_ce & rom_oe;
        rd_req_s   = ram_ce & ram_oe;
        wr_req_s   = ram_ce & ram_we;
        rom_edge_s = rom_req_s & ~rom_prev_r;
        rd_edge_s  = rd_req_s & ~rd_prev_r;
        wr_edge_s  = wr_req_s & ~wr_prev_r;

        // A fresh edge overrides any queued request of the same kind.
        rom_addr_s = rom_edge_s ? rom_addr : rom_addr_r;
        rd_addr_s  = rd_edge_s ? ram_addr : rd_addr_r;
        wr_addr_s  = wr_edge_s ? ram_addr : wr_addr_r;
        wr_data_s  = wr_edge_s ? ram_dati : wr_data_r;

        // Edges are visible in the same cycle so an idle launch costs no extra clock.
        want_rom_s = pend_rom_r | rom_edge_s;
        want_rd_s  = pend_rd_r | rd_edge_s;
        want_wr_s  = pend_wr_r | wr_edge_s;
        want_any_s = want_rom_s | want_rd_s | want_wr_s;

        if (want_rom_s) begin
            launch_kind_s = K_ROM_RD;
        end else if (want_wr_s) begin
            launch_kind_s = K_RAM_WR;
        end else begin
            launch_kind_s = K_RAM_RD;
        end

        case (launch_kind_s)
            K_ROM_RD: launch_addr_s = {2'b00, rom_addr_s};
            K_RAM_WR: launch_addr_s = RAM_BASE + {4'b0000, wr_addr_s};
            default:  launch_addr_s = RAM_BASE + {4'b0000, rd_addr_s};
        endcase

        state_s     = state_r;
        cnt_s       = cnt_r;
        kind_s      = kind_r;
        pend_rom_s  = want_rom_s;
        pend_rd_s   = want_rd_s;
        pend_wr_s   = want_wr_s;
        rom_dato_s  = rom_dato;
        ram_dato_s  = ram_dato;
        mem_addr_s  = mem_addr;
        mem_dq_o_s  = mem_dq_o;
        mem_dq_oe_s = mem_dq_oe;
        mem_ce_n_s  = mem_ce_n;
        mem_oe_n_s  = mem_oe_n;
        mem_we_n_s  = mem_we_n;

        case (state_r)
            ST_IDLE, ST_HOLD: begin
                mem_oe_n_s = 1'b1;
                mem_we_n_s = 1'b1;
                if (want_any_s) begin
                    state_s     = ST_SETUP;
                    kind_s      = launch_kind_s;
                    mem_addr_s  = launch_addr_s;
                    mem_ce_n_s  = 1'b0;
                    mem_dq_oe_s = (launch_kind_s == K_RAM_WR);
                    if (launch_kind_s == K_RAM_WR) begin
                        mem_dq_o_s = wr_data_s;
                        pend_wr_s  = 1'b0;
                    end else if (launch_kind_s == K_ROM_RD) begin
                        pend_rom_s = 1'b0;
                    end else begin
                        pend_rd_s = 1'b0;
                    end
                end else begin
                    state_s     = ST_IDLE;
                    mem_ce_n_s  = 1'b1;
                    mem_dq_oe_s = 1'b0;
                end
            end
            ST_SETUP: begin
                state_s = ST_STROBE;
                if (kind_r == K_RAM_WR) begin
                    cnt_s      = WR_LOAD;
                    mem_we_n_s = 1'b0;
                    mem_oe_n_s = 1'b1;
                end else begin
                    cnt_s      = ACC_LOAD;
                    mem_oe_n_s = 1'b0;
                    mem_we_n_s = 1'b1;
                end
            end
            ST_STROBE: begin
                if (cnt_r == 4'd0) begin
                    state_s    = ST_HOLD;
                    mem_oe_n_s = 1'b1;
                    mem_we_n_s = 1'b1;
                    if (kind_r == K_ROM_RD) begin
                        rom_dato_s = mem_dq_i;
                    end else if (kind_r == K_RAM_RD) begin
                        ram_dato_s = mem_dq_i;
                    end else begin
                        rom_dato_s = rom_dato;
                    end
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                mem_ce_n_s  = 1'b1;
                mem_oe_n_s  = 1'b1;
                mem_we_n_s  = 1'b1;
                mem_dq_oe_s = 1'b0;
            end
        endcase

        busy_s = (state_s != ST_IDLE) | pend_rom_s | pend_rd_s | pend_wr_s;
    end

    // State, request queue and registered bus/read-data outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 4'd0;
            kind_r     <= K_ROM_RD;
            rom_prev_r <= 1'b0;
            rd_prev_r  <= 1'b0;
            wr_prev_r  <= 1'b0;
            pend_rom_r <= 1'b0;
            pend_rd_r  <= 1'b0;
            pend_wr_r  <= 1'b0;
            rom_addr_r <= 20'd0;
            rd_addr_r  <= 18'd0;
            wr_addr_r  <= 18'd0;
            wr_data_r  <= 8'd0;
            rom_dato   <= 8'hFF;
            ram_dato   <= 8'hFF;
            busy       <= 1'b0;
            mem_addr   <= 22'd0;
            mem_dq_o   <= 8'd0;
            mem_dq_oe  <= 1'b0;
            mem_ce_n   <= 1'b1;
            mem_oe_n   <= 1'b1;
            mem_we_n   <= 1'b1;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            kind_r     <= kind_s;
            rom_prev_r <= rom_req_s;
            rd_prev_r  <= rd_req_s;
            wr_prev_r  <= wr_req_s;
            pend_rom_r <= pend_rom_s;
            pend_rd_r  <= pend_rd_s;
            pend_wr_r  <= pend_wr_s;
            rom_addr_r <= rom_addr_s;
            rd_addr_r  <= rd_addr_s;
            wr_addr_r  <= wr_addr_s;
            wr_data_r  <= wr_data_s;
            rom_dato   <= rom_dato_s;
            ram_dato   <= ram_dato_s;
            busy       <= busy_s;
            mem_addr   <= mem_addr_s;
            mem_dq_o   <= mem_dq_o_s;
            mem_dq_oe  <= mem_dq_oe_s;
            mem_ce_n   <= mem_ce_n_s;
            mem_oe_n   <= mem_oe_n_s;
            mem_we_n   <= mem_we_n_s;
        end
    end

endmodule

// File: tb/tb_huc_mem_seq.sv
// Directed testbench for huc_mem_seq with a behavioural SRAM model.
module tb_huc_mem_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rom_ce = 1'b0, rom_oe = 1'b0;
    logic [19:0] rom_addr = 20'd0;
    logic        ram_ce = 1'b0, ram_oe = 1'b0, ram_we = 1'b0;
    logic [17:0] ram_addr = 18'd0;
    logic [7:0]  ram_dati = 8'd0;
    logic [7:0]  rom_dato, ram_dato;
    logic        busy;
    logic [21:0] mem_addr;
    logic [7:0]  mem_dq_o;
    logic        mem_dq_oe;
    logic [7:0]  mem_dq_i = 8'd0;
    logic        mem_ce_n, mem_oe_n, mem_we_n;

    // Second instance only to observe address wrap with a high RAM base.
    logic [7:0]  w_rom_dato, w_ram_dato, w_dq_o;
    logic        w_busy, w_dq_oe, w_ce_n, w_oe_n, w_we_n;
    logic [21:0] w_addr;
    logic [7:0]  w_dq_i = 8'd0;

    logic [7:0]  mem_model [logic [21:0]];
    int          checks = 0;
    int          errors = 0;
    logic        mon_en = 1'b0;

    huc_mem_seq dut (
        .clk(clk), .rst_n(rst_n),
        .rom_ce(rom_ce), .rom_oe(rom_oe), .rom_addr(rom_addr),
        .ram_ce(ram_ce), .ram_oe(ram_oe), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_dati(ram_dati),
        .rom_dato(rom_dato), .ram_dato(ram_dato), .busy(busy),
        .mem_addr(mem_addr), .mem_dq_o(mem_dq_o), .mem_dq_oe(mem_dq_oe),
        .mem_dq_i(mem_dq_i), .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n),
        .mem_we_n(mem_we_n)
    );

    huc_mem_seq #(.RAM_BASE(22'h3F0000)) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .rom_ce(rom_ce), .rom_oe(rom_oe), .rom_addr(rom_addr),
        .ram_ce(ram_ce), .ram_oe(ram_oe), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_dati(ram_dati),
        .rom_dato(w_rom_dato), .ram_dato(w_ram_dato), .busy(w_busy),
        .mem_addr(w_addr), .mem_dq_o(w_dq_o), .mem_dq_oe(w_dq_oe),
        .mem_dq_i(w_dq_i), .mem_ce_n(w_ce_n), .mem_oe_n(w_oe_n),
        .mem_we_n(w_we_n)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rd_model(input logic [21:0] a);
        if (mem_model.exists(a)) begin
            return mem_model[a];
        end else begin
            return 8'h00;
        end
    endfunction

    // SRAM model and bus-protocol monitor, updated away from the active edge.
    always @(negedge clk) begin
        mem_dq_i = (!mem_ce_n && !mem_oe_n) ? rd_model(mem_addr) : 8'h00;
        if (!mem_ce_n && !mem_we_n && mem_dq_oe) begin
            mem_model[mem_addr] = mem_dq_o;
        end
        if (mon_en) begin
            checks++;
            assert (!(!mem_oe_n && !mem_we_n) && !(mem_dq_oe && !mem_oe_n)) else begin
                errors++;
                $error("FAIL bus_protocol: observed oe_n=%0b we_n=%0b dq_oe=%0b required no overlap",
                       mem_oe_n, mem_we_n, mem_dq_oe);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    int lows;
    int dq_hi;
    int ce_low;
    int falls;
    logic prev_oe;

    initial begin
        mem_model[22'h012345] = 8'hA5;
        mem_model[22'h000010] = 8'h77;
        mem_model[22'h000100] = 8'h11;
        mem_model[22'h000200] = 8'h22;

        // Reset state
        rst_n = 1'b0;
        tick(); tick(); tick();
        check("rst_rom_dato", {24'd0, rom_dato}, 32'hFF);
        check("rst_ram_dato", {24'd0, ram_dato}, 32'hFF);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_addr", {10'd0, mem_addr}, 32'd0);
        check("rst_dq_o", {24'd0, mem_dq_o}, 32'd0);
        check("rst_strobes", {28'd0, mem_dq_oe, mem_ce_n, mem_oe_n, mem_we_n}, 32'h7);
        rst_n = 1'b1;
        tick();
        mon_en = 1'b1;

        // ROM read at 20'h12345
        rom_ce = 1'b1; rom_oe = 1'b1; rom_addr = 20'h12345;
        tick();
        rom_oe = 1'b0;
        check("rom_setup_addr", {10'd0, mem_addr}, 32'h012345);
        check("rom_setup_ce", {30'd0, mem_ce_n, mem_oe_n}, 32'h1);
        check("rom_setup_busy", {31'd0, busy}, 32'd1);
        lows = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (mem_oe_n === 1'b0) lows++;
        end
        check("rom_oe_low_cycles", lows, 32'd4);
        tick();
        check("rom_hold_oe", {31'd0, mem_oe_n}, 32'd1);
        check("rom_dato", {24'd0, rom_dato}, 32'hA5);
        check("rom_hold_busy", {30'd0, busy, mem_ce_n}, 32'h2);
        tick();
        check("rom_idle", {30'd0, busy, mem_ce_n}, 32'h1);

        // RAM write 8'h3C at 18'h10000
        ram_ce = 1'b1; ram_we = 1'b1; ram_addr = 18'h10000; ram_dati = 8'h3C;
        tick();
        ram_we = 1'b0;
        check("wr_setup_addr", {10'd0, mem_addr}, 32'h110000);
        check("wr_setup_dq", {22'd0, mem_dq_oe, mem_we_n, mem_dq_o}, {22'd0, 2'b11, 8'h3C});
        lows = 0; dq_hi = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (mem_we_n === 1'b0) lows++;
            if (mem_dq_oe === 1'b1) dq_hi++;
        end
        check("wr_we_low_cycles", lows, 32'd3);
        check("wr_dq_oe_strobe", dq_hi, 32'd3);
        tick();
        check("wr_hold", {29'd0, mem_we_n, mem_dq_oe, mem_ce_n}, 32'h6);
        tick();
        check("wr_idle", {30'd0, mem_dq_oe, busy}, 32'd0);

        // RAM read back of the same address
        ram_oe = 1'b1;
        tick();
        ram_oe = 1'b0;
        check("rd_setup_addr", {10'd0, mem_addr}, 32'h110000);
        wait_idle("rd_done");
        check("ram_dato", {24'd0, ram_dato}, 32'h3C);

        // Simultaneous ROM read and RAM write edges
        rom_oe = 1'b1; rom_addr = 20'h00010;
        ram_we = 1'b1; ram_addr = 18'h00020; ram_dati = 8'h5A;
        tick();
        rom_oe = 1'b0; ram_we = 1'b0;
        check("tie_first_addr", {10'd0, mem_addr}, 32'h000010);
        ce_low = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (mem_ce_n === 1'b0) ce_low++;
        end
        check("tie_no_idle_gap", ce_low, 32'd6);
        check("tie_second_addr", {10'd0, mem_addr}, 32'h100020);
        check("tie_second_dq", {23'd0, mem_dq_oe, mem_dq_o}, {23'd0, 1'b1, 8'h5A});
        check("tie_rom_dato", {24'd0, rom_dato}, 32'h77);
        wait_idle("tie_done");

        // Held ROM strobe gives exactly one access
        rom_oe = 1'b1;
        falls = 0; prev_oe = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (i == 20) rom_oe = 1'b0;
            tick();
            if (prev_oe === 1'b1 && mem_oe_n === 1'b0) falls++;
            prev_oe = mem_oe_n;
        end
        check("held_single_access", falls, 32'd1);
        check("held_idle", {31'd0, busy}, 32'd0);

        // Second ROM edge during STROBE is queued
        rom_oe = 1'b1; rom_addr = 20'h00100;
        tick();
        rom_oe = 1'b0;
        tick();
        check("queue_in_strobe", {31'd0, mem_oe_n}, 32'd0);
        rom_oe = 1'b1; rom_addr = 20'h00200;
        tick();
        rom_oe = 1'b0;
        tick(); tick(); tick();
        check("queue_first_dato", {24'd0, rom_dato}, 32'h11);
        check("queue_first_addr", {10'd0, mem_addr}, 32'h000100);
        tick();
        check("queue_second_addr", {10'd0, mem_addr}, 32'h000200);
        check("queue_second_ce", {30'd0, mem_ce_n, busy}, 32'h1);
        wait_idle("queue_done");
        check("queue_second_dato", {24'd0, rom_dato}, 32'h22);

        // RAM address wrap with the high-base instance
        ram_oe = 1'b1; ram_addr = 18'h3FFFF;
        tick();
        ram_oe = 1'b0;
        check("wrap_addr", {10'd0, w_addr}, 32'h02FFFF);
        check("nowrap_addr", {10'd0, mem_addr}, 32'h13FFFF);
        wait_idle("wrap_done");

        // Reset during a write strobe aborts the access
        ram_we = 1'b1; ram_addr = 18'h00001; ram_dati = 8'h99;
        tick();
        ram_we = 1'b0;
        tick(); tick();
        check("abort_in_strobe", {31'd0, mem_we_n}, 32'd0);
        mon_en = 1'b0;
        rst_n = 1'b0;
        tick();
        check("abort_strobes", {29'd0, mem_we_n, mem_ce_n, mem_dq_oe}, 32'h6);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_dato", {16'd0, rom_dato, ram_dato}, 32'hFFFF);
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/huc_mem_seq.md
Name: huc_mem_seq

Overview:
- Downstream stage of the HuCard mapper. Consumes the mapper's ROM and RAM memory-control requests and sequences them onto one shared 8-bit asynchronous external SRAM bus.
- Applies programmable setup, strobe and hold timing, and returns latched read data to the mapper.
- ROM and cart RAM share the physical device. RAM sits at a fixed base offset.

Parameters:
- T_ACC, 4, read strobe length in clk cycles (1..15).
- T_WR, 3, write strobe length in clk cycles (1..15).
- RAM_BASE, 22'h100000, physical base address of the cart RAM window.

Ports:
- clk  in  1  system clock; all inputs are synchronous to it.
- rst_n  in  1  synchronous active-low reset.
- rom_ce  in  1  ROM select.
- rom_oe  in  1  ROM read strobe.
- rom_addr  in  20  ROM byte address.
- ram_ce  in  1  RAM select.
- ram_oe  in  1  RAM read strobe.
- ram_we  in  1  RAM write strobe.
- ram_addr  in  18  RAM byte address.
- ram_dati  in  8  RAM write data.
- rom_dato  out  8  latched ROM read data.
- ram_dato  out  8  latched RAM read data.
- busy  out  1  sequencer not idle or a request is pending.
- mem_addr  out  22  external address.
- mem_dq_o  out  8  external write data.
- mem_dq_oe  out  1  drive enable for mem_dq_o.
- mem_dq_i  in  8  external read data.
- mem_ce_n  out  1  external chip enable, active low.
- mem_oe_n  out  1  external output enable, active low.
- mem_we_n  out  1  external write enable, active low.

Behaviour:
- Reset values:
  - rom_dato = 8'hFF, ram_dato = 8'hFF, busy = 0, mem_addr = 0, mem_dq_o = 0.
  - mem_dq_oe = 0, mem_ce_n = mem_oe_n = mem_we_n = 1, state = IDLE, pending flags clear.
- Reset asserted mid-access aborts the access in that same clock edge. No write completes and no data is latched.
- Request detection, on the rising edge of the qualified strobe (registered previous value):
  - rom_rd = rom_ce & rom_oe
  - ram_rd = ram_ce & ram_oe
  - ram_wr = ram_ce & ram_we
- A strobe held high never retriggers. A detected edge sets the matching pending flag (rom_rd, ram_rd, ram_wr).
- ram_wr captures ram_addr and ram_dati at detection. Read requests capture their address at detection.
- Arbitration when leaving IDLE, one request per access: rom_rd first, then ram_wr, then ram_rd. Ties happen only from simultaneous edges.
- The pending flag clears when its access enters SETUP. Edges arriving while busy are queued in their flag. A second edge of the same kind while its flag is set is merged: the newest address and data win.
- Address mapping:
  - ROM: mem_addr = {2'b00, rom_addr}.
  - RAM: mem_addr = RAM_BASE + {4'b0, ram_addr}, modulo 2^22.
- States:
  - IDLE: all strobes inactive. Any pending flag moves to SETUP.
  - SETUP (1 cycle): mem_addr valid, mem_ce_n = 0. For writes, mem_dq_o valid and mem_dq_oe = 1.
  - STROBE (T_ACC or T_WR cycles): mem_oe_n = 0 for reads, mem_we_n = 0 for writes. Uses a 4-bit down counter.
  - HOLD (1 cycle): strobes inactive. mem_ce_n = 0, address and data held. For reads, mem_dq_i is captured on the clk edge that ends the last STROBE cycle.
- HOLD goes to SETUP if any flag is pending, else IDLE. mem_ce_n returns to 1 in IDLE.
- Read data: the captured byte goes to rom_dato or ram_dato according to the request. Each dato holds until the next completed read of its own port.
- Total read latency from the edge-detect cycle to dato update is 1 + T_ACC clk cycles when idle.
- busy = (state != IDLE) | any pending flag.
- mem_oe_n and mem_we_n are never low together. mem_dq_oe is never 1 during a read access.

Test Plan:
- Reset, then a rom_rd edge at rom_addr = 20'h12345 with model memory [22'h012345] = 8'hA5:
  - mem_addr = 22'h012345.
  - mem_oe_n low for exactly 4 cycles.
  - rom_dato = 8'hA5 one cycle after the strobe ends; busy falls after HOLD.
- ram_wr at ram_addr = 18'h10000 with data 8'h3C:
  - mem_addr = 22'h110000, mem_we_n low 3 cycles, mem_dq_oe = 1 from SETUP through HOLD.
  - A following ram_rd of the same address returns ram_dato = 8'h3C.
- rom_rd and ram_wr edges in the same cycle: ROM access first, RAM write immediately after with no IDLE cycle between.
- rom_oe held high for 20 cycles: exactly one external access.
- A second rom_rd edge during STROBE is queued and executes after HOLD.
- ram_addr = 18'h3FFFF with RAM_BASE = 22'h3F0000: mem_addr wraps to 22'h02FFFF.
- rst_n = 0 during a write STROBE: the next edge shows mem_we_n = 1, mem_ce_n = 1, mem_dq_oe = 0, busy = 0, and both dato = 8'hFF.
